// File: rtl/e32_fetch.sv
// Instruction fetch stage: one-deep request pipeline into a 2-entry {instr, pc} FIFO,
// with redirect squash and valid/ready handoff to the control unit.
module e32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_data_i,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  logic [31:0] fetch_pc_p0;
  logic        inflight_p1;
  logic [31:0] inflight_pc_p1;
  logic [31:0] fifo_instr_p2 [2];
  logic [31:0] fifo_pc_p2    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        head_valid;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  demand;
  logic [31:0] redirect_pc;

  assign redirect_pc = redirect_addr & 32'hFFFF_FFFC;

  assign head_valid  = reset && (count != 2'd0);
  assign instr_valid = head_valid && !redirect;
  assign pop         = instr_valid && instr_ready;
  // A response landing on a redirect or reset cycle belongs to the old stream.
  assign push        = inflight_p1 && reset && !redirect;

  // Slots already promised (buffered + in flight) after this cycle's pop.
  assign demand = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, pop};
  assign issue  = reset && enable && !redirect && (demand < 3'd2);

  assign mem_req  = issue;
  assign mem_addr = reset ? fetch_pc_p0 : RESET_PC;
  assign instr    = head_valid ? fifo_instr_p2[rd_ptr] : 32'h0;
  assign instr_pc = head_valid ? fifo_pc_p2[rd_ptr]    : 32'h0;

  // p0 -> p1: request issue and fetch PC advance; FIFO control.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_p0 <= RESET_PC;
      inflight_p1 <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else if (redirect) begin
      fetch_pc_p0 <= redirect_pc;
      inflight_p1 <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
      inflight_p1 <= issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // p1 -> p2: response capture into the FIFO tail.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= fetch_pc_p0;
    if (push) begin
      fifo_instr_p2[wr_ptr] <= mem_data_i;
      fifo_pc_p2[wr_ptr]    <= inflight_pc_p1;
    end
  end

endmodule

// File: tb/tb_e32_fetch.sv
// Bench for e32_fetch: directed vector table plus randomized run against a queue-based model.
module tb_e32_fetch;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset, enable, redirect, instr_ready;
  logic [31:0] redirect_addr, mem_data_i, mem_data2;
  logic [31:0] mem_addr, instr, instr_pc;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr2, instr2, instr_pc2;
  logic        mem_req2, instr_valid2;

  e32_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_data_i(mem_data_i), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  e32_fetch #(.RESET_PC(RST_PC2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mem_addr(mem_addr2), .mem_req(mem_req2),
    .mem_data_i(mem_data2), .redirect(1'b0), .redirect_addr(32'h0),
    .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, rdy, rdr;
    logic [31:0] raddr;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  int checks = 0;
  int errors = 0;

  entry_t      q[$];
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = 32'h0;
  logic [31:0] m_pc = RST_PC;
  logic        prev_req = 1'b0, prev_req2 = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_addr2 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, en, rdy, rdr, input logic [31:0] ra,
                              input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.rdr = rdr; v.raddr = ra;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic run_cycle(input vec_t v, input bit use_tbl, input int idx);
    int     n;
    logic   m_valid, m_pop, m_issue;
    logic [31:0] exp_pc2;
    reset = v.rst; enable = v.en; instr_ready = v.rdy;
    redirect = v.rdr; redirect_addr = v.raddr;
    mem_data_i = prev_req  ? (prev_addr  ^ K) : $urandom();
    mem_data2  = prev_req2 ? (prev_addr2 ^ K) : $urandom();
    #3;
    n       = q.size();
    m_valid = v.rst && !v.rdr && (n > 0);
    m_pop   = m_valid && v.rdy;
    m_issue = v.rst && v.en && !v.rdr && ((n + int'(m_infl) - int'(m_pop)) < 2);

    chk("model_mem_req", {31'b0, mem_req}, {31'b0, m_issue});
    if (m_issue || !v.rst) chk("model_mem_addr", mem_addr, v.rst ? m_pc : RST_PC);
    chk("model_instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("model_instr", instr, q[0].instr);
      chk("model_instr_pc", instr_pc, q[0].pc);
    end
    if (!v.rst) begin
      chk("reset_instr", instr, 32'h0);
      chk("reset_instr_pc", instr_pc, 32'h0);
    end

    if (use_tbl) begin
      chk("tbl_mem_req", {31'b0, mem_req}, {31'b0, v.req});
      if (v.req || !v.rst) chk("tbl_mem_addr", mem_addr, v.addr);
      chk("tbl_instr_valid", {31'b0, instr_valid}, {31'b0, v.vld});
      if (v.vld) begin
        chk("tbl_instr_pc", instr_pc, v.pc);
        chk("tbl_instr", instr, v.pc ^ K);
      end
      if (idx >= 4 && idx <= 7) begin
        exp_pc2 = RST_PC2 + 32'(4 * (idx - 4));
        chk("wrap_valid", {31'b0, instr_valid2}, 32'd1);
        chk("wrap_instr_pc", instr_pc2, exp_pc2);
        chk("wrap_instr", instr2, exp_pc2 ^ K);
      end
    end

    prev_req  = mem_req;  prev_addr  = mem_addr;
    prev_req2 = mem_req2; prev_addr2 = mem_addr2;

    if (!v.rst) begin
      q.delete(); m_infl = 1'b0; m_pc = RST_PC;
    end else if (v.rdr) begin
      q.delete(); m_infl = 1'b0; m_pc = v.raddr & 32'hFFFF_FFFC;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_infl) q.push_back('{instr: mem_data_i, pc: m_infl_pc});
      m_infl = m_issue;
      if (m_issue) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t rv;
    reset = 1'b0; enable = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_addr = 32'h0; mem_data_i = 32'h0; mem_data2 = 32'h0;

    //         rst en rdy rdr raddr        req addr          vld pc
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,    0, RST_PC,       0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,    0, RST_PC,       0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,    1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,    1, 32'h4,        0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,    0, 32'h8,        1, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,    0, 32'h8,        1, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,    0, 32'h8,        1, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h8,        1, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'hC,        1, 32'h4));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h10,       1, 32'h8));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h14,       1, 32'hC));
    tbl.push_back(mk(1, 1, 1, 1, 32'h103,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h100,      0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h104,      0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h108,      1, 32'h100));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h10C,      1, 32'h104));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,    0, 32'h0,        1, 32'h108));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,    0, 32'h0,        1, 32'h10C));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,    0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h110,      0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h114,      0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h118,      1, 32'h110));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,    0, RST_PC,       0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h4,        0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 0, 32'h0,    1, 32'h8,        1, 32'h0));

    @(posedge clk); #1;
    foreach (tbl[i]) run_cycle(tbl[i], 1'b1, i);

    // Back-to-back redirects: the last address wins.
    run_cycle(mk(1, 1, 1, 1, 32'h0000_2000, 0, 0, 0, 0), 1'b0, 0);
    run_cycle(mk(1, 1, 1, 1, 32'h0000_3006, 0, 0, 0, 0), 1'b0, 0);
    run_cycle(mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0), 1'b0, 0);
    chk("redirect_last_addr", prev_addr, 32'h0000_3004);
    chk("redirect_first_req", {31'b0, prev_req}, 32'd1);

    for (int c = 0; c < 2000; c++) begin
      rv = mk(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 14) == 0),
              $urandom(), 0, 0, 0, 0);
      run_cycle(rv, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e32_fetch.md
E32_FETCH -- requirements
Module: e32_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  core enable; 0 blocks new memory requests only.
REQ-005 SHALL have port mem_addr  output  32  instruction read address.
REQ-006 SHALL have port mem_req  output  1  read strobe; mem_addr valid when 1.
REQ-007 SHALL have port mem_data_i  input  32  read data, valid exactly one cycle after a cycle with mem_req=1.
REQ-008 SHALL have port redirect  input  1  branch/jump redirect request from execute.
REQ-009 SHALL have port redirect_addr  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-010 SHALL have port instr  output  32  instruction word to the control unit.
REQ-011 SHALL have port instr_pc  output  32  address of instr.
REQ-012 SHALL have port instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-013 SHALL have port instr_ready  input  1  control unit accepts; transfer (pop) when instr_valid & instr_ready.

Function
REQ-014 SHALL hold a 2-entry in-order FIFO of {instr, pc}; instr/instr_pc/instr_valid SHALL be driven from the FIFO head (registered, no bypass from mem_data_i).
REQ-015 SHALL track one in-flight bit: set by an issue, cleared when the response arrives the next cycle.
REQ-016 SHALL issue (mem_req=1, mem_addr=fetch_pc) in a cycle iff reset=1, enable=1, redirect=0, and occupancy + inflight - pop < 2.
REQ-017 On issue SHALL advance fetch_pc by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-018 A response SHALL be written to the FIFO tail with pc = address issued, unless squashed.
REQ-019 Simultaneous push and pop SHALL be permitted at any occupancy, including full (pop frees the slot); occupancy never exceeds 2 and no response is ever dropped except by squash.
REQ-020 Steady state with enable=1 and instr_ready=1 SHALL sustain one issue and one pop per cycle.
REQ-021 Latency: issue in cycle N -> data in cycle N+1 -> instr_valid=1 in cycle N+2.
REQ-022 enable=0 SHALL not affect the in-flight response capture or the output handshake.
REQ-023 instr_valid SHALL stay asserted and instr/instr_pc stable until popped (no retraction except by redirect or reset).
REQ-024 redirect=1 SHALL take priority over all other events in that cycle: no issue, no pop, instr_valid forced 0 combinationally.
REQ-025 On redirect the next cycle SHALL see: FIFO empty, fetch_pc = {redirect_addr[31:2],2'b00}, any in-flight response squashed.
REQ-026 Back-to-back redirects SHALL each take effect; the last one defines fetch_pc.
REQ-027 First issue after redirect SHALL occur in the cycle after redirect (if enable=1) at the redirect address.

Reset
REQ-028 While reset=0 SHALL hold: fetch_pc=RESET_PC, FIFO empty, inflight=0, mem_req=0, instr_valid=0, mem_addr=RESET_PC, instr=0, instr_pc=0.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight response (data arriving the cycle after reset is ignored).
REQ-030 First issue SHALL occur in the first cycle with reset=1 and enable=1.

Verification
REQ-031 Reset release, enable=1, ready=1, memory returns addr^32'hA5A5_0000: mem_req cycles 0,1,2...; instr_valid from cycle 2; instr_pc 0,4,8 with matching data, one per cycle.
REQ-032 ready=0 for 5 cycles after first fetch: exactly 2 entries buffered (pc 0,4), mem_req=0 thereafter; on ready=1, pops pc 0,4,8 in order with no gap or duplicate.
REQ-033 redirect with redirect_addr=32'h0000_0103 while FIFO full and a request in flight: next cycle instr_valid=0, mem_addr=0x100; first valid entry has instr_pc=0x100; old data never appears.
REQ-034 RESET_PC=32'hFFFF_FFF8, ready=1: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-035 enable=0 in the cycle after an issue: in-flight word still delivered; no further mem_req until enable=1; fetch resumes at next sequential address.
REQ-036 reset=0 for one cycle while an issue is in flight: data returned during reset cycle dropped; first post-reset entry has instr_pc=RESET_PC.
